// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared CPU definitions used by the fetch unit.
package inst_fetch_unit_pkg;
   localparam int XLEN_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} fetch_state_t;
endpackage

// File: rtl/inst_fetch_unit_inst_queue.sv
// inst_queue: power-of-two circular FIFO with flush; storage is unreset and masked by count.
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     en,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic do_pop;
   assign do_pop = pop && (count != '0);
   assign head_data = mem[head];
   always_ff @(posedge clk_in)
      if (!rst_in && en && !flush && push) begin
         mem[tail] <= push_data;
         assert (count < CW'(DEPTH));
      end
   always_ff @(posedge clk_in)
      if (rst_in || (en && flush)) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (en) begin
         tail  <= push ? tail + 1'b1 : tail;
         head  <= do_pop ? head + 1'b1 : head;
         count <= count + CW'(push) - CW'(do_pop);
      end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding fetch FSM feeding a decoder-facing instruction queue.
module inst_fetch_unit import inst_fetch_unit_pkg::*; #(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              IQ_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   output logic            mem_req_valid,
   output logic [XLEN-1:0] mem_req_pc,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_inst,
   output logic [XLEN-1:0] pred_query_pc,
   input  logic [XLEN-1:0] pred_next_pc,
   output logic            dec_valid,
   output logic [XLEN-1:0] dec_inst,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_pred_pc,
   input  logic            dec_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);
   localparam int CW = $clog2(IQ_DEPTH) + 1;
   fetch_state_t state, next_state;
   logic [XLEN-1:0] fetch_pc, next_pc;
   logic [CW-1:0] count;
   logic [3*XLEN-1:0] head_data;
   logic push, pop;
   inst_queue #(.DEPTH(IQ_DEPTH), .WIDTH(3*XLEN)) u_queue (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en        (rdy_in),
      .flush     (redirect_valid),
      .push      (push),
      .pop       (pop),
      .push_data ({mem_resp_inst, fetch_pc, pred_next_pc}),
      .count     (count),
      .head_data (head_data)
   );
   assign mem_req_valid = (state == WAIT);
   assign mem_req_pc    = fetch_pc;
   assign pred_query_pc = fetch_pc;
   assign dec_valid     = (count != '0);
   assign pop           = dec_valid && dec_ready;
   assign dec_inst      = dec_valid ? head_data[3*XLEN-1:2*XLEN] : '0;
   assign dec_pc        = dec_valid ? head_data[2*XLEN-1:XLEN] : '0;
   assign dec_pred_pc   = dec_valid ? head_data[XLEN-1:0] : '0;
   always_comb begin
      next_state = state;
      next_pc    = redirect_valid ? redirect_pc : fetch_pc;
      push       = 1'b0;
      case (state)
         IDLE: next_state = (!redirect_valid && count < CW'(IQ_DEPTH)) ? WAIT : IDLE;
         WAIT:
            if (redirect_valid)
               next_state = mem_resp_valid ? IDLE : DISCARD;
            else if (mem_resp_valid) begin
               push       = 1'b1;
               next_pc    = pred_next_pc;
               next_state = IDLE;
            end
         // a stale response is still owed by memctrl; swallow it before issuing again
         DISCARD: next_state = mem_resp_valid ? IDLE : DISCARD;
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk_in)
      if (rst_in) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else if (rdy_in) begin
         state    <= next_state;
         fetch_pc <= next_pc;
      end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: cycle-table and hand-sequence checks of the fetch unit with a pc+4 predictor.
module tb_inst_fetch_unit;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, mem_resp_valid, dec_ready, redirect_valid;
   logic [31:0] mem_resp_inst, redirect_pc, pred_next_pc;
   logic        mem_req_valid, dec_valid;
   logic [31:0] mem_req_pc, pred_query_pc, dec_inst, dec_pc, dec_pred_pc;
   int          n_checks = 0;
   int          n_fail = 0;
   typedef struct {
      string        name;
      logic         rdy, resp, drdy, redir;
      logic [31:0]  inst, rpc;
      logic [129:0] exp;
   } vec_t;
   vec_t tbl[$];
   inst_fetch_unit #(.XLEN(32), .IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .mem_req_valid  (mem_req_valid),
      .mem_req_pc     (mem_req_pc),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_inst  (mem_resp_inst),
      .pred_query_pc  (pred_query_pc),
      .pred_next_pc   (pred_next_pc),
      .dec_valid      (dec_valid),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc),
      .dec_pred_pc    (dec_pred_pc),
      .dec_ready      (dec_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );
   always #5 clk_in = ~clk_in;
   // predictor: pc+4 everywhere except a taken branch at 0x8
   assign pred_next_pc = (pred_query_pc == 32'h8) ? 32'h200 : pred_query_pc + 32'h4;
   function automatic logic [129:0] ex(logic mreq, logic [31:0] mpc, logic dv,
                                       logic [31:0] dpc, logic [31:0] dinst, logic [31:0] dpred);
      return {mreq, mpc, dv, dpc, dinst, dpred};
   endfunction
   function automatic vec_t mk(string name, logic rdy, logic resp, logic [31:0] inst, logic drdy,
                               logic redir, logic [31:0] rpc, logic [129:0] exp);
      vec_t v;
      v.name = name; v.rdy = rdy; v.resp = resp; v.inst = inst;
      v.drdy = drdy; v.redir = redir; v.rpc = rpc; v.exp = exp;
      return v;
   endfunction
   task automatic check(string name, logic [129:0] exp);
      logic [129:0] got;
      got = {mem_req_valid, mem_req_pc, dec_valid, dec_pc, dec_inst, dec_pred_pc};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {req,req_pc,dv,pc,inst,pred}=%h expected %h", name, got, exp);
      end
   endtask
   task automatic drive(logic rdy, logic resp, logic [31:0] inst, logic drdy, logic redir, logic [31:0] rpc);
      rdy_in = rdy; mem_resp_valid = resp; mem_resp_inst = inst;
      dec_ready = drdy; redirect_valid = redir; redirect_pc = rpc;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      tbl.push_back(mk("issue0",      1, 0, 0,      0, 0, 0,     ex(1, 32'h0,   0, 0, 0, 0)));
      tbl.push_back(mk("wait0",       1, 0, 0,      0, 0, 0,     ex(1, 32'h0,   0, 0, 0, 0)));
      tbl.push_back(mk("resp0",       1, 1, 32'h13, 0, 0, 0,     ex(0, 32'h4,   1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("issue4",      1, 0, 0,      0, 0, 0,     ex(1, 32'h4,   1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("resp4",       1, 1, 32'h17, 0, 0, 0,     ex(0, 32'h8,   1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("issue8",      1, 0, 0,      0, 0, 0,     ex(1, 32'h8,   1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("resp8_pred",  1, 1, 32'h23, 0, 0, 0,     ex(0, 32'h200, 1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("issue200",    1, 0, 0,      0, 0, 0,     ex(1, 32'h200, 1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("resp_full",   1, 1, 32'h33, 0, 0, 0,     ex(0, 32'h204, 1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("full_hold1",  1, 0, 0,      0, 0, 0,     ex(0, 32'h204, 1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("full_hold2",  1, 0, 0,      0, 0, 0,     ex(0, 32'h204, 1, 32'h0, 32'h13, 32'h4)));
      tbl.push_back(mk("pop_full",    1, 0, 0,      1, 0, 0,     ex(0, 32'h204, 1, 32'h4, 32'h17, 32'h8)));
      tbl.push_back(mk("pop_issue",   1, 0, 0,      1, 0, 0,     ex(1, 32'h204, 1, 32'h8, 32'h23, 32'h200)));
      tbl.push_back(mk("redir_wait",  1, 0, 0,      0, 1, 32'h80, ex(0, 32'h80, 0, 0, 0, 0)));
      tbl.push_back(mk("discard1",    1, 0, 0,      0, 0, 0,     ex(0, 32'h80,  0, 0, 0, 0)));
      tbl.push_back(mk("discard2",    1, 0, 0,      0, 0, 0,     ex(0, 32'h80,  0, 0, 0, 0)));
      tbl.push_back(mk("stale_drop",  1, 1, 32'hdead, 0, 0, 0,   ex(0, 32'h80,  0, 0, 0, 0)));
      tbl.push_back(mk("issue80",     1, 0, 0,      0, 0, 0,     ex(1, 32'h80,  0, 0, 0, 0)));
      tbl.push_back(mk("redir_resp",  1, 1, 32'h99, 0, 1, 32'h300, ex(0, 32'h300, 0, 0, 0, 0)));
      tbl.push_back(mk("issue300",    1, 0, 0,      0, 0, 0,     ex(1, 32'h300, 0, 0, 0, 0)));
      tbl.push_back(mk("resp300",     1, 1, 32'h41, 0, 0, 0,     ex(0, 32'h304, 1, 32'h300, 32'h41, 32'h304)));
      tbl.push_back(mk("issue304",    1, 0, 0,      0, 0, 0,     ex(1, 32'h304, 1, 32'h300, 32'h41, 32'h304)));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk($sformatf("frozen%0d", i), 0, (i == 2), 32'hbad, 1, 0, 0,
                          ex(1, 32'h304, 1, 32'h300, 32'h41, 32'h304)));
      tbl.push_back(mk("thaw_pop",    1, 0, 0,      1, 0, 0,     ex(1, 32'h304, 0, 0, 0, 0)));
      tbl.push_back(mk("resp304",     1, 1, 32'h51, 1, 0, 0,     ex(0, 32'h308, 1, 32'h304, 32'h51, 32'h308)));
      tbl.push_back(mk("issue_pop",   1, 0, 0,      1, 0, 0,     ex(1, 32'h308, 0, 0, 0, 0)));
      tbl.push_back(mk("resp308",     1, 1, 32'h61, 1, 0, 0,     ex(0, 32'h30c, 1, 32'h308, 32'h61, 32'h30c)));
      tbl.push_back(mk("issue30c",    1, 0, 0,      0, 0, 0,     ex(1, 32'h30c, 1, 32'h308, 32'h61, 32'h30c)));
      tbl.push_back(mk("push_pop",    1, 1, 32'h71, 1, 0, 0,     ex(0, 32'h310, 1, 32'h30c, 32'h71, 32'h310)));
      tbl.push_back(mk("redir_idle",  1, 0, 0,      0, 1, 32'h40, ex(0, 32'h40, 0, 0, 0, 0)));
      tbl.push_back(mk("issue40",     1, 0, 0,      0, 0, 0,     ex(1, 32'h40,  0, 0, 0, 0)));
      rst_in = 1'b1;
      drive(0, 1, 32'h77, 1, 1, 32'h500);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      check("reset_state", ex(0, 32'h0, 0, 0, 0, 0));
      rst_in = 1'b0;
      foreach (tbl[i]) begin
         drive(tbl[i].rdy, tbl[i].resp, tbl[i].inst, tbl[i].drdy, tbl[i].redir, tbl[i].rpc);
         @(posedge clk_in); #1;
         check(tbl[i].name, tbl[i].exp);
      end
      // reset while waiting, frozen and redirected: reset must win
      rst_in = 1'b1;
      drive(0, 1, 32'h55, 0, 1, 32'h500);
      @(posedge clk_in); #1;
      check("reset_mid_wait", ex(0, 32'h0, 0, 0, 0, 0));
      rst_in = 1'b0;
      drive(1, 0, 0, 0, 0, 0);
      n = 0;
      while (!mem_req_valid && n < 8) begin @(posedge clk_in); #1; n++; end
      check("memctrl_req0", ex(1, 32'h0, 0, 0, 0, 0));
      @(posedge clk_in); #1;
      drive(1, 1, 32'h13, 0, 0, 0);
      @(posedge clk_in); #1;
      drive(1, 0, 0, 0, 0, 0);
      check("memctrl_deliver0", ex(0, 32'h4, 1, 32'h0, 32'h13, 32'h4));
      n = 0;
      while (!mem_req_valid && n < 8) begin @(posedge clk_in); #1; n++; end
      check("memctrl_req4", ex(1, 32'h4, 1, 32'h0, 32'h13, 32'h4));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: width of PCs and instruction words.
REQ-002 Parameter IQ_DEPTH, default 4: instruction queue entries; a power of two, 2..16.
REQ-003 Parameter RESET_PC, default 32'h0: fetch PC after reset.
REQ-004 Port clk_in  input  1: single clock, all state updates on the rising edge.
REQ-005 Port rst_in  input  1: reset, synchronous, active-high.
REQ-006 Port rdy_in  input  1: global ready; low freezes all state.
REQ-007 Port mem_req_valid  output  1: fetch request to memctrl.
REQ-008 Port mem_req_pc  output  XLEN: address of the pending fetch.
REQ-009 Port mem_resp_valid  input  1: one-cycle pulse, instruction returned.
REQ-010 Port mem_resp_inst  input  XLEN: returned instruction, valid with mem_resp_valid.
REQ-011 Port pred_query_pc  output  XLEN: combinational copy of the current fetch PC.
REQ-012 Port pred_next_pc  input  XLEN: predictor's next PC for pred_query_pc, same cycle.
REQ-013 Port dec_valid  output  1: queue head is valid.
REQ-014 Port dec_inst / dec_pc / dec_pred_pc  output  XLEN each: head instruction, its PC, its predicted next PC.
REQ-015 Port dec_ready  input  1: decoder accepts the head this cycle.
REQ-016 Port redirect_valid  input  1: misprediction or flush from the commit side.
REQ-017 Port redirect_pc  input  XLEN: corrected fetch PC, valid with redirect_valid.

Function
REQ-018 FSM states: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (outstanding response is stale).
REQ-019 IDLE->WAIT when count < IQ_DEPTH and redirect_valid is low; mem_req_valid is high in WAIT only.
REQ-020 mem_req_pc holds fetch_pc steady for the whole of WAIT; one request outstanding at most.
REQ-021 WAIT with mem_resp_valid: push {mem_resp_inst, fetch_pc, pred_next_pc}; fetch_pc <= pred_next_pc; go to IDLE.
REQ-022 Fetch latency: response edge + 1 cycle to dec_valid; the next request issues in the cycle after the response.
REQ-023 dec_valid = (count != 0); pop when dec_valid && dec_ready; head pointer wraps modulo IQ_DEPTH.
REQ-024 Push and pop in the same cycle: count unchanged, both pointers advance.
REQ-025 The queue never overflows because issue requires count < IQ_DEPTH; a push into a full queue is illegal and is asserted in simulation.
REQ-026 dec_inst, dec_pc and dec_pred_pc read 0 whenever dec_valid is low.
REQ-027 redirect_valid has priority over push, pop and issue; it empties the queue (count, head, tail <= 0) and sets fetch_pc <= redirect_pc.
REQ-028 Redirect in WAIT without mem_resp_valid: go to DISCARD.
REQ-029 Redirect in WAIT with mem_resp_valid in the same cycle: drop the response and go to IDLE.
REQ-030 DISCARD with mem_resp_valid: drop the response and go to IDLE; a redirect in DISCARD updates fetch_pc and stays in DISCARD.
REQ-031 rdy_in low: no state, pointer or PC changes; outputs hold their values; mem_resp_valid is ignored.

Reset
REQ-032 When rst_in is high at a clock edge: state=IDLE, fetch_pc=RESET_PC, count=head=tail=0, mem_req_valid=0, dec_valid=0; the data outputs read 0.
REQ-033 Reset overrides rdy_in and redirect_valid; a response pending at reset is discarded, and memctrl is reset together with this block.
REQ-034 Queue storage is not reset; it is masked by count.

Structure
REQ-035 XLEN default, RESET_PC and the FSM state encodings live in the shared CPU definitions package.
REQ-036 One sub-module, inst_queue: a parametrised circular FIFO (IQ_DEPTH, width 3*XLEN) with push, pop, flush, count and head read.
REQ-037 The FSM, fetch_pc register and redirect logic stay in inst_fetch_unit.

Verification
REQ-038 Reset, then memctrl returns 32'h00000013 after 2 cycles, predictor returns pc+4 -> requests at 0x0 and 0x4, dec_pc=0x0, dec_inst=0x13.
REQ-039 dec_ready held 0, IQ_DEPTH=4 -> exactly 4 pushes, then mem_req_valid stays 0; one pop -> a new request at 0x10.
REQ-040 redirect_pc=0x80 during WAIT, response arrives 3 cycles later -> response dropped, queue empty, next request at 0x80.
REQ-041 redirect and mem_resp_valid in the same cycle -> nothing pushed, IDLE, request at redirect_pc on the next cycle.
REQ-042 rdy_in low for 5 cycles mid-WAIT with dec_ready high -> count, pointers, mem_req_pc and dec_* unchanged; resumes without loss.
REQ-043 Predictor returns 0x200 for pc 0x8 -> entry has dec_pred_pc=0x200, and the next request is at 0x200.
